// File: rtl/tsqr_sched_pkg.sv
// Shared types and constants for the TSQR tile scheduler and its drain sequencer.
package tsqr_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_COMPUTE,
      ST_DRAIN,
      ST_NEXT,
      ST_FAIL
   } state_e;

   localparam int TIMEOUT_CYC_DEF = 65535;
   localparam int NUM_BANKS_DEF   = 3;
   localparam int TILE_W          = 16;
   localparam int ADDR_W          = 8;
   localparam int WDOG_W          = 16;

   // Bank index width; a single bank still needs one bit to index.
   function automatic int bankWidth(input int nBanks);
      return (nBanks > 1) ? $clog2(nBanks) : 1;
   endfunction

endpackage

// File: rtl/tsqr_drain_seq.sv
// Walks bank 0..NUM_BANKS-1, address 0..BANK_DEPTH-1, issuing one-cycle-latency
// reads and holding the returned word until the sink takes it.
module tsqr_drain_seq
   import tsqr_sched_pkg::*;
#(
   parameter int NUM_BANKS  = NUM_BANKS_DEF,
   parameter int BANK_DEPTH = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 init_i,
   input  logic                 active_i,
   input  logic                 drain_ready_i,
   output logic [NUM_BANKS-1:0] dma_mem_enb_o,
   output logic [ADDR_W-1:0]    dma_mem_addrb_o,
   output logic                 drain_valid_o,
   output logic                 drain_last_o,
   output logic                 last_accept_o
);

   localparam int                BANK_W    = bankWidth(NUM_BANKS);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BANK_DEPTH - 1);
   localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

   logic [BANK_W-1:0] bank_q, bank_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              issuedAll_q, issuedAll_d;
   logic              held_q, held_d;
   logic              heldLast_q, heldLast_d;
   logic              issue;
   logic              accept;
   logic              finalRead;

   // A read may go out only when the holding slot is empty or being emptied this cycle.
   always_comb begin
      accept    = held_q & drain_ready_i;
      issue     = active_i & ~issuedAll_q & (~held_q | drain_ready_i);
      finalRead = (bank_q == LAST_BANK) && (addr_q == LAST_ADDR);
      for (int i = 0; i < NUM_BANKS; i++) begin
         dma_mem_enb_o[i] = issue && (bank_q == BANK_W'(i));
      end
   end

   // Next position in the bank/address walk and the state of the holding slot.
   always_comb begin
      bank_d      = bank_q;
      addr_d      = addr_q;
      issuedAll_d = issuedAll_q;
      held_d      = held_q;
      heldLast_d  = heldLast_q;
      if (init_i) begin
         bank_d      = '0;
         addr_d      = '0;
         issuedAll_d = 1'b0;
         held_d      = 1'b0;
         heldLast_d  = 1'b0;
      end else begin
         if (accept) begin
            held_d     = 1'b0;
            heldLast_d = 1'b0;
         end
         if (issue) begin
            held_d     = 1'b1;
            heldLast_d = finalRead;
            if (finalRead) begin
               issuedAll_d = 1'b1;
            end else if (addr_q == LAST_ADDR) begin
               addr_d = '0;
               bank_d = bank_q + 1'b1;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
      end
   end

   // Sequencer registers; reset throws away any word still held.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bank_q      <= '0;
         addr_q      <= '0;
         issuedAll_q <= 1'b0;
         held_q      <= 1'b0;
         heldLast_q  <= 1'b0;
      end else begin
         bank_q      <= bank_d;
         addr_q      <= addr_d;
         issuedAll_q <= issuedAll_d;
         held_q      <= held_d;
         heldLast_q  <= heldLast_d;
      end
   end

   assign dma_mem_addrb_o = addr_q;
   assign drain_valid_o   = held_q;
   assign drain_last_o    = heldLast_q;
   assign last_accept_o   = accept & heldLast_q;

endmodule

// File: rtl/tsqr_tile_scheduler.sv
// Run-level sequencing of TSQR tiles: load inputs, wait for the core, drain the
// result banks, repeat for each tile, with a compute watchdog.
module tsqr_tile_scheduler
   import tsqr_sched_pkg::*;
#(
   parameter int NUM_BANKS   = NUM_BANKS_DEF,
   parameter int BANK_DEPTH  = 256,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [TILE_W-1:0]    num_tiles,
   input  logic                 src_valid,
   output logic [TILE_W-1:0]    tile_no,
   output logic                 data_rdy,
   input  logic                 tsqr_fi,
   input  logic [15:0]          mx_cnt,
   output logic [NUM_BANKS-1:0] dma_mem_enb,
   output logic [ADDR_W-1:0]    dma_mem_addrb,
   output logic                 drain_valid,
   output logic                 drain_last,
   input  logic                 drain_ready,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [15:0]          last_mx
);

   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);

   state_e            state_q, state_d;
   logic [TILE_W-1:0] tileNo_q, tileNo_d;
   logic [TILE_W-1:0] numTiles_q, numTiles_d;
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic [15:0]       lastMx_q, lastMx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic              dataRdy_q, dataRdy_d;
   logic              drainInit;
   logic              lastAccept;

   // Next-state and registered-output decisions; tsqr_fi beats a same-cycle watchdog expiry.
   always_comb begin
      state_d    = state_q;
      tileNo_d   = tileNo_q;
      numTiles_d = numTiles_q;
      wdog_d     = wdog_q;
      lastMx_d   = lastMx_q;
      busy_d     = busy_q;
      error_d    = error_q;
      done_d     = 1'b0;
      dataRdy_d  = 1'b0;
      drainInit  = 1'b0;
      case (state_q)
         ST_IDLE, ST_FAIL: begin
            if (start) begin
               error_d = 1'b0;
               if (num_tiles != '0) begin
                  numTiles_d = num_tiles;
                  tileNo_d   = '0;
                  busy_d     = 1'b1;
                  state_d    = ST_LOAD;
               end else begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_LOAD: begin
            if (src_valid) begin
               dataRdy_d = 1'b1;
               wdog_d    = '0;
               state_d   = ST_COMPUTE;
            end
         end
         ST_COMPUTE: begin
            if (tsqr_fi) begin
               lastMx_d  = mx_cnt;
               drainInit = 1'b1;
               state_d   = ST_DRAIN;
            end else if (wdog_q == WDOG_LAST) begin
               error_d = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_FAIL;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (lastAccept) begin
               state_d = ST_NEXT;
            end
         end
         ST_NEXT: begin
            if (({1'b0, tileNo_q} + 17'd1) < {1'b0, numTiles_q}) begin
               tileNo_d = tileNo_q + 1'b1;
               state_d  = ST_LOAD;
            end else begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and status registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         tileNo_q   <= '0;
         numTiles_q <= '0;
         wdog_q     <= '0;
         lastMx_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         dataRdy_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tileNo_q   <= tileNo_d;
         numTiles_q <= numTiles_d;
         wdog_q     <= wdog_d;
         lastMx_q   <= lastMx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         dataRdy_q  <= dataRdy_d;
      end
   end

   tsqr_drain_seq #(
      .NUM_BANKS  (NUM_BANKS),
      .BANK_DEPTH (BANK_DEPTH)
   ) uDrainSeq (
      .clk             (clk),
      .rst             (rst),
      .init_i          (drainInit),
      .active_i        (state_q == ST_DRAIN),
      .drain_ready_i   (drain_ready),
      .dma_mem_enb_o   (dma_mem_enb),
      .dma_mem_addrb_o (dma_mem_addrb),
      .drain_valid_o   (drain_valid),
      .drain_last_o    (drain_last),
      .last_accept_o   (lastAccept)
   );

   assign tile_no  = tileNo_q;
   assign data_rdy = dataRdy_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign error    = error_q;
   assign last_mx  = lastMx_q;

endmodule
